rr_arbiter4: RTL and testbench

- Four-requester round-robin arbiter with grant locking and an optional hold timeout.
- Sequential counterpart to the team's 4-to-2 encoder / 2-to-4 decoder pair.
- Encodes the winning request into a 2-bit index and drives the matching one-hot grant.
- Shares one downstream resource (bus, decoder select, memory port) among four masters.

---
 rtl/arb_pkg.sv | 9 +
 rtl/rr_pick4.sv | 21 ++
 rtl/rr_arbiter4.sv | 74 +++++++
 tb/tb_rr_arbiter4.sv | 122 ++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// arb_pkg: shared sizes and state encoding for the round-robin arbiter
package arb_pkg;
    localparam int N_REQ = 4;
    localparam int IDX_W = 2;
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;
endpackage

// File: rtl/rr_pick4.sv
// rr_pick4: rotating-priority pick of the first set request starting at ptr
module rr_pick4
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             any
);
    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    logic [IDX_W-1:0]   off;
    // rotate so ptr lands at bit 0, then 4-to-2 priority encode and rotate the index back
    always_comb begin
        dbl = {req, req};
        rot = dbl[ptr +: N_REQ];
        off = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
        idx = ptr + off;
        any = |req;
    end
endmodule

// File: rtl/rr_arbiter4.sv
// rr_arbiter4: four-requester round-robin arbiter with grant locking and hold timeout
module rr_arbiter4
    import arb_pkg::*;
#(
    parameter int HOLD_MAX = 16,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             preempt
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(HOLD_MAX == 0 ? 0 : HOLD_MAX - 1);

    state_t           state, state_n;
    logic [IDX_W-1:0] ptr, ptr_n, idx_n, win;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             pre_n, any, timeout;

    rr_pick4 u_pick (
        .req (req),
        .ptr (ptr),
        .idx (win),
        .any (any)
    );

    // owner's index doubles as the decoder select, so grant is one-hot by construction
    always_comb begin
        gnt_valid = (state == ST_GRANT);
        gnt       = {3'b000, gnt_valid} << gnt_idx;
    end

    // next state: lock on winner, hold while owner requests, release on drop or timeout
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        idx_n   = gnt_idx;
        cnt_n   = cnt;
        pre_n   = 1'b0;
        timeout = (HOLD_MAX != 0) && (cnt == LAST);
        if (state == ST_IDLE) begin
            state_n = any ? ST_GRANT : ST_IDLE;
            idx_n   = any ? win : gnt_idx;
            cnt_n   = '0;
        end else if (!req[gnt_idx] || timeout) begin
            state_n = ST_IDLE;
            ptr_n   = gnt_idx + 2'd1;
            cnt_n   = '0;
            pre_n   = req[gnt_idx];
        end else begin
            cnt_n = (cnt == '1) ? cnt : cnt + CNT_W'(1);
        end
    end

    // state, pointer, counter and registered outputs; reset drops any grant silently
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            ptr     <= '0;
            cnt     <= '0;
            gnt_idx <= '0;
            preempt <= 1'b0;
        end else begin
            state   <= state_n;
            ptr     <= ptr_n;
            cnt     <= cnt_n;
            gnt_idx <= idx_n;
            preempt <= pre_n;
        end
    end
endmodule

// File: tb/tb_rr_arbiter4.sv
// tb_rr_arbiter4: directed checks of ordering, wrap, timeout and reset behaviour
module tb_rr_arbiter4;
    import arb_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid, preempt;
    logic [3:0] own;
    int         n_chk = 0;
    int         n_fail = 0;

    rr_arbiter4 #(.HOLD_MAX(4), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .preempt   (preempt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] eg, input logic ep);
        logic [1:0] ei;
        ei = eg[1] ? 2'd1 : eg[2] ? 2'd2 : eg[3] ? 2'd3 : 2'd0;
        n_chk++;
        assert (gnt === eg) else begin
            n_fail++;
            $error("FAIL %s gnt=%b expected=%b", tag, gnt, eg);
        end
        n_chk++;
        assert (gnt_valid === (eg != 4'b0000)) else begin
            n_fail++;
            $error("FAIL %s gnt_valid=%b expected=%b", tag, gnt_valid, eg != 4'b0000);
        end
        n_chk++;
        assert (preempt === ep) else begin
            n_fail++;
            $error("FAIL %s preempt=%b expected=%b", tag, preempt, ep);
        end
        if (eg != 4'b0000) begin
            n_chk++;
            assert (gnt_idx === ei) else begin
                n_fail++;
                $error("FAIL %s gnt_idx=%0d expected=%0d", tag, gnt_idx, ei);
            end
        end
    endtask

    task automatic step(input string tag, input logic [3:0] eg, input logic ep);
        @(posedge clk);
        @(negedge clk);
        check(tag, eg, ep);
    endtask

    task automatic check_idx(input string tag, input logic [1:0] ei);
        n_chk++;
        assert (gnt_idx === ei) else begin
            n_fail++;
            $error("FAIL %s gnt_idx=%0d expected=%0d", tag, gnt_idx, ei);
        end
    endtask

    initial begin
        rst = 1'b1;
        req = 4'b1111;
        step("rst_0", 4'b0000, 1'b0);
        step("rst_1", 4'b0000, 1'b0);
        rst = 1'b0;
        step("first_grant", 4'b0001, 1'b0);
        for (int k = 0; k < 4; k++) begin
            own = 4'b0001 << k;
            step("rr_hold1", own, 1'b0);
            step("rr_hold2", own, 1'b0);
            req = 4'b1111 & ~own;
            step("rr_gap", 4'b0000, 1'b0);
            req = 4'b1111;
            step("rr_next", (k == 3) ? 4'b0001 : own << 1, 1'b0);
        end
        req = 4'b0000;
        step("wrap_gap0", 4'b0000, 1'b0);
        req = 4'b0100;
        step("wrap_g2", 4'b0100, 1'b0);
        req = 4'b0001;
        step("wrap_gap2", 4'b0000, 1'b0);
        req = 4'b0101;
        step("wrap_skip", 4'b0001, 1'b0);
        req = 4'b0000;
        step("to_gap", 4'b0000, 1'b0);
        req = 4'b0010;
        for (int k = 0; k < 4; k++) step("to_hold", 4'b0010, 1'b0);
        step("to_preempt", 4'b0000, 1'b1);
        check_idx("to_idx_kept", 2'd1);
        step("to_regrant", 4'b0010, 1'b0);
        req = 4'b0000;
        step("tf_gap", 4'b0000, 1'b0);
        req = 4'b0011;
        for (int k = 0; k < 4; k++) step("tf_hold0", 4'b0001, 1'b0);
        step("tf_pre0", 4'b0000, 1'b1);
        for (int k = 0; k < 4; k++) step("tf_hold1", 4'b0010, 1'b0);
        step("tf_pre1", 4'b0000, 1'b1);
        step("tf_back0", 4'b0001, 1'b0);
        req = 4'b0000;
        step("mr_gap", 4'b0000, 1'b0);
        req = 4'b0100;
        step("mr_g2_c0", 4'b0100, 1'b0);
        step("mr_g2_c1", 4'b0100, 1'b0);
        step("mr_g2_c2", 4'b0100, 1'b0);
        rst = 1'b1;
        step("mr_rst", 4'b0000, 1'b0);
        check_idx("mr_rst_idx", 2'd0);
        rst = 1'b0;
        req = 4'b1100;
        step("mr_after", 4'b0100, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
